// File: rtl/i2c_expander_pkg.sv
// Shared definitions for the SFP GPIO expander initiator and target.
// Register map, reset values and the target state encoding live here.
package i2c_expander_pkg;

    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h20;

    localparam logic [1:0] REG_INPUT    = 2'd0;
    localparam logic [1:0] REG_OUTPUT   = 2'd1;
    localparam logic [1:0] REG_POLARITY = 2'd2;
    localparam logic [1:0] REG_CONFIG   = 2'd3;

    localparam logic [7:0] OUTPUT_RST   = 8'hFF;
    localparam logic [7:0] POLARITY_RST = 8'h00;
    localparam logic [7:0] CONFIG_RST   = 8'hFF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_WAIT_STOP
    } target_state_t;

endpackage

// File: rtl/i2c_expander_target_if.sv
// Bus and GPIO signals of the expander target, grouped for the top-level port.
interface i2c_expander_target_if;

    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic [7:0] gpio_in;
    logic [7:0] gpio_out;
    logic [7:0] gpio_cfg;
    logic       wr_strobe;
    logic [1:0] wr_reg;
    logic       busy;

    modport slave (
        input  scl_i, sda_i, gpio_in,
        output sda_oe, gpio_out, gpio_cfg, wr_strobe, wr_reg, busy
    );

    modport master (
        output scl_i, sda_i, gpio_in,
        input  sda_oe, gpio_out, gpio_cfg, wr_strobe, wr_reg, busy
    );

endinterface

// File: rtl/i2c_expander_target_monitor.sv
// Bus monitor: synchronizes SCL/SDA and produces single-cycle edge and
// START/STOP pulses together with the synchronized SDA level they refer to.
module i2c_bus_monitor #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_q;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // Bring the asynchronous pad levels into the clock domain; an idle bus is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
        end
    end

    // Edge and condition detect; using the current SCL level makes a same-cycle
    // SCL and SDA change behave as if SCL moved first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q    <= 1'b1;
            sda      <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
        end else begin
            scl_q    <= scl_s;
            sda      <= sda_s;
            scl_rise <= scl_s & ~scl_q;
            scl_fall <= ~scl_s & scl_q;
            start    <= scl_s & sda & ~sda_s;
            stop     <= scl_s & ~sda & sda_s;
        end
    end

endmodule

// File: rtl/i2c_expander_target.sv
// I2C target emulating the 8-bit SFP GPIO expander (Input/Output/Polarity/Config).
// Samples on SCL rising edges, changes SDA only after SCL falling edges.
module i2c_expander_target
    import i2c_expander_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    i2c_expander_target_if.slave  bus
);

    target_state_t state, state_next;
    logic          scl_rise, scl_fall, start, stop, sda;
    logic [2:0]    bit_cnt;
    logic          ack_seen;
    logic          rw;
    logic [7:0]    shift;
    logic [7:0]    byte_in;
    logic [7:0]    rd_val;
    logic [1:0]    ptr;
    logic [7:0]    out_reg, pol_reg, cfg_reg;
    logic          sda_oe_q, sda_oe_next;
    logic          wr_strobe_q;
    logic [1:0]    wr_reg_q;
    logic          byte_done;
    logic          bus_event;

    i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_monitor (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (bus.scl_i),
        .sda_i    (bus.sda_i),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop),
        .sda      (sda)
    );

    assign byte_in   = {shift[6:0], sda};
    assign byte_done = scl_rise && (bit_cnt == 3'd7);
    assign bus_event = start || stop;

    assign bus.sda_oe    = sda_oe_q;
    assign bus.gpio_out  = out_reg;
    assign bus.gpio_cfg  = cfg_reg;
    assign bus.wr_strobe = wr_strobe_q;
    assign bus.wr_reg    = wr_reg_q;

    // Register file read port; the Input register is the live pins through polarity.
    always_comb begin
        rd_val = bus.gpio_in ^ pol_reg;
        unique case (ptr)
            REG_OUTPUT:   rd_val = out_reg;
            REG_POLARITY: rd_val = pol_reg;
            REG_CONFIG:   rd_val = cfg_reg;
            default:      rd_val = bus.gpio_in ^ pol_reg;
        endcase
    end

    // Protocol state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state decode; START and STOP override whatever the byte engine is doing.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = ST_ADDR;
        end else if (stop) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_ADDR:      if (byte_done) state_next = (shift[6:0] == DEV_ADDR) ? ST_ADDR_ACK : ST_IDLE;
                ST_ADDR_ACK:  if (scl_fall && ack_seen) state_next = rw ? ST_RD_DATA : ST_PTR;
                ST_PTR:       if (byte_done) state_next = (byte_in <= 8'd3) ? ST_PTR_ACK : ST_WAIT_STOP;
                ST_PTR_ACK:   if (scl_fall && ack_seen) state_next = ST_WR_DATA;
                ST_WR_DATA:   if (byte_done) state_next = ST_WR_ACK;
                ST_WR_ACK:    if (scl_fall && ack_seen) state_next = ST_WR_DATA;
                ST_RD_DATA:   if (byte_done) state_next = ST_RD_ACK;
                ST_RD_ACK: begin
                    if (scl_rise && sda)            state_next = ST_WAIT_STOP;
                    else if (scl_fall && ack_seen)  state_next = ST_RD_DATA;
                end
                default:      state_next = state;
            endcase
        end
    end

    // SDA drive decision and busy flag; SDA only changes on an SCL falling edge.
    always_comb begin
        sda_oe_next = sda_oe_q;
        bus.busy    = (state != ST_IDLE);
        if (bus_event) begin
            sda_oe_next = 1'b0;
        end else if (scl_fall) begin
            unique case (state)
                ST_ADDR_ACK:          sda_oe_next = !ack_seen ? 1'b1 : (rw ? ~rd_val[7] : 1'b0);
                ST_PTR_ACK, ST_WR_ACK: sda_oe_next = !ack_seen;
                ST_RD_DATA:           sda_oe_next = ~shift[7];
                ST_RD_ACK:            sda_oe_next = ack_seen ? ~rd_val[7] : 1'b0;
                default:              sda_oe_next = 1'b0;
            endcase
        end
    end

    // Bit counter, shift register, register file and write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= 3'd0;
            ack_seen    <= 1'b0;
            rw          <= 1'b0;
            shift       <= 8'h00;
            ptr         <= REG_INPUT;
            out_reg     <= OUTPUT_RST;
            pol_reg     <= POLARITY_RST;
            cfg_reg     <= CONFIG_RST;
            sda_oe_q    <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_reg_q    <= 2'd0;
        end else begin
            wr_strobe_q <= 1'b0;
            sda_oe_q    <= sda_oe_next;
            if (bus_event || (state_next != state)) begin
                bit_cnt  <= 3'd0;
                ack_seen <= 1'b0;
            end else if (scl_rise) begin
                bit_cnt  <= bit_cnt + 3'd1;
                ack_seen <= 1'b1;
            end
            if (!bus_event && scl_rise) begin
                unique case (state)
                    ST_ADDR: begin
                        shift <= byte_in;
                        if (byte_done) rw <= sda;
                    end
                    ST_PTR: begin
                        shift <= byte_in;
                        if (byte_done && (byte_in <= 8'd3)) ptr <= byte_in[1:0];
                    end
                    ST_WR_DATA: begin
                        shift <= byte_in;
                        if (byte_done && (ptr != REG_INPUT)) begin
                            wr_strobe_q <= 1'b1;
                            wr_reg_q    <= ptr;
                            unique case (ptr)
                                REG_OUTPUT:   out_reg <= byte_in;
                                REG_POLARITY: pol_reg <= byte_in;
                                default:      cfg_reg <= byte_in;
                            endcase
                        end
                    end
                    default: ;
                endcase
            end else if (!bus_event && scl_fall) begin
                unique case (state)
                    ST_RD_DATA:  shift <= {shift[6:0], 1'b0};
                    ST_ADDR_ACK: if (ack_seen && rw) shift <= {rd_val[6:0], 1'b0};
                    ST_RD_ACK:   if (ack_seen) shift <= {rd_val[6:0], 1'b0};
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_expander_target.sv
// Bench for the expander target: a bit-banged I2C controller with an
// open-drain bus model and a scoreboard of expected ACKs and read bytes.
`timescale 1ns/1ps
module tb_i2c_expander_target;

    localparam int Q = 200;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       scl_m;
    logic       sda_m;
    int         checks;
    int         errors;
    int         strobe_cnt;
    int         strobe_base;
    logic [1:0] last_wr_reg;
    exp_t       sb_q[$];

    i2c_expander_target_if bus();

    assign bus.scl_i = scl_m;
    assign bus.sda_i = sda_m & ~bus.sda_oe;

    i2c_expander_target #(.DEV_ADDR(7'h20), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 50 MHz system clock.
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Log every register write strobe the target emits.
    always @(negedge clk) begin
        if (bus.wr_strobe) begin
            strobe_cnt  = strobe_cnt + 1;
            last_wr_reg = bus.wr_reg;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_output("scoreboard_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_output(e.tag, obs, e.val);
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic clock_bit(input logic b, output logic seen);
        sda_m = b;    #Q;
        scl_m = 1'b1; #Q;
        seen  = bus.sda_i; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
        clock_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(nack, s);
    endtask

    task automatic send_expect(input string tag, input logic [7:0] d, input logic exp_ack);
        logic a;
        sb_push(tag, 32'(exp_ack));
        write_byte(d, a);
        sb_pop_check(32'(a));
    endtask

    task automatic apply_stimulus(input logic [7:0] p, input logic [7:0] d);
        i2c_start();
        send_expect("ack_addr_w", 8'h40, 1'b1);
        send_expect("ack_ptr", p, 1'b1);
        send_expect("ack_data", d, 1'b1);
        i2c_stop();
        #Q;
    endtask

    task automatic read_expect(input string tag, input logic [7:0] p, input logic [7:0] exp_val);
        logic [7:0] d;
        i2c_start();
        send_expect("ack_addr_w", 8'h40, 1'b1);
        send_expect("ack_ptr", p, 1'b1);
        i2c_start();
        send_expect("ack_addr_r", 8'h41, 1'b1);
        sb_push(tag, 32'(exp_val));
        read_byte(1'b1, d);
        sb_pop_check(32'(d));
        check_output("sda_release_after_nack", 32'(bus.sda_oe), 32'd0);
        i2c_stop();
        #Q;
    endtask

    initial begin
        logic s;
        checks      = 0;
        errors      = 0;
        strobe_cnt  = 0;
        last_wr_reg = 2'd0;
        rst_n       = 1'b0;
        scl_m       = 1'b1;
        sda_m       = 1'b1;
        bus.gpio_in = 8'h00;
        #Q;
        check_output("rst_sda_oe",    32'(bus.sda_oe),    32'd0);
        check_output("rst_wr_strobe", 32'(bus.wr_strobe), 32'd0);
        check_output("rst_wr_reg",    32'(bus.wr_reg),    32'd0);
        check_output("rst_busy",      32'(bus.busy),      32'd0);
        check_output("rst_gpio_out",  32'(bus.gpio_out),  32'hFF);
        check_output("rst_gpio_cfg",  32'(bus.gpio_cfg),  32'hFF);
        rst_n = 1'b1;
        #Q;

        // Plain write of the Output register.
        strobe_base = strobe_cnt;
        i2c_start();
        check_output("busy_after_start", 32'(bus.busy), 32'd1);
        send_expect("ack_addr_w", 8'h40, 1'b1);
        send_expect("ack_ptr", 8'h01, 1'b1);
        send_expect("ack_data", 8'h5A, 1'b1);
        i2c_stop();
        #Q;
        check_output("wr_gpio_out",   32'(bus.gpio_out), 32'h5A);
        check_output("wr_strobe_cnt", 32'(strobe_cnt - strobe_base), 32'd1);
        check_output("wr_reg_out",    32'(last_wr_reg), 32'd1);
        check_output("busy_after_stop", 32'(bus.busy), 32'd0);

        // Polarity applied to the Input register on read.
        bus.gpio_in = 8'h3C;
        apply_stimulus(8'h02, 8'h0F);
        check_output("wr_reg_pol", 32'(last_wr_reg), 32'd2);
        strobe_base = strobe_cnt;
        read_expect("rd_input", 8'h00, 8'h33);
        check_output("rd_no_strobe", 32'(strobe_cnt - strobe_base), 32'd0);

        // Wrong address is not acknowledged.
        i2c_start();
        send_expect("ack_bad_addr", 8'h42, 1'b0);
        check_output("busy_bad_addr", 32'(bus.busy), 32'd0);
        i2c_stop();
        #Q;
        check_output("bad_addr_gpio_out", 32'(bus.gpio_out), 32'h5A);

        // Out-of-range pointer is refused and the following byte ignored.
        i2c_start();
        send_expect("ack_addr_w", 8'h40, 1'b1);
        send_expect("nack_ptr7", 8'h07, 1'b0);
        send_expect("nack_data_after_ptr7", 8'h55, 1'b0);
        i2c_stop();
        #Q;
        check_output("ptr7_no_strobe", 32'(strobe_cnt - strobe_base), 32'd0);

        // Repeated writes to Config, then a byte aborted by STOP.
        i2c_start();
        send_expect("ack_addr_w", 8'h40, 1'b1);
        send_expect("ack_ptr", 8'h03, 1'b1);
        send_expect("ack_cfg0", 8'h00, 1'b1);
        send_expect("ack_cfg1", 8'h81, 1'b1);
        check_output("cfg_strobe_cnt", 32'(strobe_cnt - strobe_base), 32'd2);
        check_output("cfg_value", 32'(bus.gpio_cfg), 32'h81);
        clock_bit(1'b1, s);
        clock_bit(1'b0, s);
        clock_bit(1'b1, s);
        clock_bit(1'b0, s);
        i2c_stop();
        #Q;
        check_output("abort_cfg_value", 32'(bus.gpio_cfg), 32'h81);
        check_output("abort_strobe_cnt", 32'(strobe_cnt - strobe_base), 32'd2);
        check_output("abort_busy", 32'(bus.busy), 32'd0);

        // Reset asserted while the target drives a 0 read bit.
        i2c_start();
        send_expect("ack_addr_w", 8'h40, 1'b1);
        send_expect("ack_ptr", 8'h01, 1'b1);
        i2c_start();
        send_expect("ack_addr_r", 8'h41, 1'b1);
        check_output("rd_first_bit_drive", 32'(bus.sda_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("midrst_sda_oe",   32'(bus.sda_oe),   32'd0);
        check_output("midrst_gpio_out", 32'(bus.gpio_out), 32'hFF);
        check_output("midrst_gpio_cfg", 32'(bus.gpio_cfg), 32'hFF);
        check_output("midrst_busy",     32'(bus.busy),     32'd0);
        #(Q - 1);
        sda_m = 1'b1;
        scl_m = 1'b1;
        #Q;
        rst_n = 1'b1;
        #Q;

        // Normal traffic after the reset.
        apply_stimulus(8'h01, 8'hA5);
        check_output("post_rst_gpio_out", 32'(bus.gpio_out), 32'hA5);
        read_expect("rd_output", 8'h01, 8'hA5);

        check_output("scoreboard_leftover", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
